uart_rx_buffer: RTL and testbench

//  Byte FIFO between the UART receiver and the control block.

---
 rtl/uart_rx_buffer_if.sv | 27 ++
 rtl/uart_rx_buffer.sv | 82 ++++++++
 tb/tb_uart_rx_buffer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_buffer_if.sv
// Handshake bundle between the UART receiver/consumer side and the byte FIFO.
interface uart_rx_buffer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              rx_status;
  logic [DATA_W-1:0] rx_data;
  logic              rd_en;
  logic              clr_ovf;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;

  // Environment side: drives receiver data, pops and overflow clear.
  modport master (
    output rx_status, rx_data, rd_en, clr_ovf,
    input  rd_data, rd_valid, full, count, overflow
  );

  // Buffer side.
  modport slave (
    input  rx_status, rx_data, rd_en, clr_ovf,
    output rd_data, rd_valid, full, count, overflow
  );
endinterface

// File: rtl/uart_rx_buffer.sv
// Byte FIFO between the UART receiver and the control block. Captures one byte per rising
// edge of rx_status, presents the oldest byte first-word-fall-through and flags dropped
// bytes with a sticky overflow bit.
module uart_rx_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input logic             clk,
  input logic             reset,
  uart_rx_buffer_if.slave bus
);

  localparam logic [ADDR_W:0]   CntOne  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CntFull = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PtrOne  = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              rx_status_q;

  logic wr_req, pop, wr_ok, drop, rd_valid, full;

  assign rd_valid = (count_q != '0);
  assign full     = (count_q == CntFull);
  assign wr_req   = bus.rx_status & ~rx_status_q;
  assign pop      = bus.rd_en & rd_valid;
  // A full buffer still accepts a byte when the same cycle frees a slot.
  assign wr_ok    = wr_req & (~full | pop);
  assign drop     = wr_req & full & ~pop;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop)   rd_ptr_d = rd_ptr_q + PtrOne;
    unique case ({wr_ok, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
    if (bus.clr_ovf) ovf_d = 1'b0;
    // A drop in the same cycle as a clear wins.
    if (drop)        ovf_d = 1'b1;
  end

  // State registers; edge detector resets high so a level held through reset is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      rx_status_q <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      rx_status_q <= bus.rx_status;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= bus.rx_data;
  end

  assign bus.rd_valid = rd_valid;
  assign bus.full     = full;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
  assign bus.rd_data  = rd_valid ? mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: directed scenarios plus randomized traffic, all
// compared against a queue-based reference model.
module tb_uart_rx_buffer;

  localparam int DEPTH = 16;

  logic clk;
  logic reset;

  uart_rx_buffer_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  uart_rx_buffer #(
    .DATA_W(8),
    .DEPTH (DEPTH),
    .ADDR_W(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue of stored bytes, the previous rx_status level and the flag.
  byte unsigned q[$];
  bit           m_prev;
  bit           m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(q.size() != 0));
    check({tag, ".rd_data"},  32'(bus.rd_data),  (q.size() != 0) ? 32'(q[0]) : 32'd0);
    check({tag, ".count"},    32'(bus.count),    32'(q.size()));
    check({tag, ".full"},     32'(bus.full),     32'(q.size() == DEPTH));
    check({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
  endtask

  // One clock: drive inputs, advance the model with the same inputs, then compare.
  task automatic tick(input bit rx, input logic [7:0] d, input bit rd, input bit clr,
                      input string tag);
    bit wr, pop, drop;
    bus.rx_status = rx;
    bus.rx_data   = d;
    bus.rd_en     = rd;
    bus.clr_ovf   = clr;
    @(posedge clk);
    wr     = rx && !m_prev;
    m_prev = rx;
    pop    = rd && (q.size() != 0);
    drop   = wr && (q.size() == DEPTH) && !pop;
    if (pop) void'(q.pop_front());
    if (wr && !drop) q.push_back(d);
    if (clr)  m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
    #1;
    check_all(tag);
  endtask

  // Write one byte as a one-cycle pulse followed by a low cycle.
  task automatic put_byte(input logic [7:0] d, input string tag);
    tick(1'b1, d, 1'b0, 1'b0, tag);
    tick(1'b0, 8'h00, 1'b0, 1'b0, tag);
  endtask

  // Asserts reset between clock edges and checks the outputs clear without a clock edge.
  task automatic apply_reset(input bit rx_level, input string tag);
    bus.rx_status = rx_level;
    bus.rx_data   = 8'h00;
    bus.rd_en     = 1'b0;
    bus.clr_ovf   = 1'b0;
    #2 reset = 1'b0;
    #1;
    q.delete();
    m_ovf  = 1'b0;
    m_prev = 1'b1;
    check_all({tag, ".async"});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick(rx_level, 8'h00, 1'b0, 1'b0, {tag, ".rel"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b0;
    bus.rx_status = 1'b0;
    bus.rx_data   = 8'h00;
    bus.rd_en     = 1'b0;
    bus.clr_ovf   = 1'b0;
    m_prev        = 1'b1;
    m_ovf         = 1'b0;
    #1;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick(1'b0, 8'h00, 1'b0, 1'b0, "idle");

    // 1: single byte then pop
    tick(1'b1, 8'hA5, 1'b0, 1'b0, "t1_wr");
    check("t1_data", 32'(bus.rd_data), 32'h0A5);
    check("t1_count", 32'(bus.count), 32'd1);
    tick(1'b0, 8'h00, 1'b1, 1'b0, "t1_pop");
    check("t1_empty", 32'(bus.rd_data), 32'd0);
    tick(1'b0, 8'h00, 1'b1, 1'b0, "t1_pop_empty");

    // 2: long level gives one write; level held through reset gives none
    for (int i = 0; i < 10; i++) tick(1'b1, 8'h3C, 1'b0, 1'b0, "t2_level");
    check("t2_count", 32'(bus.count), 32'd1);
    tick(1'b0, 8'h00, 1'b0, 1'b0, "t2_low");
    apply_reset(1'b1, "t2_rst");
    for (int i = 0; i < 5; i++) tick(1'b1, 8'h3C, 1'b0, 1'b0, "t2_held");
    check("t2_held_count", 32'(bus.count), 32'd0);
    tick(1'b0, 8'h00, 1'b0, 1'b0, "t2_low2");

    // 3: fill, overflow, drain in order
    for (int i = 0; i < 16; i++) put_byte(8'(i), "t3_fill");
    check("t3_full", 32'(bus.full), 32'd1);
    put_byte(8'hFF, "t3_drop");
    check("t3_ovf", 32'(bus.overflow), 32'd1);
    check("t3_count", 32'(bus.count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("t3_order", 32'(bus.rd_data), 32'(i));
      tick(1'b0, 8'h00, 1'b1, 1'b0, "t3_drain");
    end
    tick(1'b0, 8'h00, 1'b0, 1'b1, "t3_clr");

    // 4: full buffer, write with same-cycle pop
    for (int i = 0; i < 16; i++) put_byte(8'h10 + 8'(i), "t4_fill");
    tick(1'b1, 8'hEE, 1'b1, 1'b0, "t4_wrpop");
    check("t4_count", 32'(bus.count), 32'd16);
    check("t4_ovf", 32'(bus.overflow), 32'd0);
    tick(1'b0, 8'h00, 1'b0, 1'b0, "t4_low");
    for (int i = 0; i < 15; i++) tick(1'b0, 8'h00, 1'b1, 1'b0, "t4_drain");
    check("t4_last", 32'(bus.rd_data), 32'h0EE);
    tick(1'b0, 8'h00, 1'b1, 1'b0, "t4_drain_last");

    // 5: wrap-around with write/pop pairs, then overflow clear priority
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 8'(i), 1'b1, 1'b0, "t5_wr");
      check("t5_data", 32'(bus.rd_data), 32'(8'(i)));
      tick(1'b0, 8'h00, 1'b1, 1'b0, "t5_pop");
    end
    for (int i = 0; i < 16; i++) put_byte(8'(8'h80 + i), "t5_fill");
    tick(1'b1, 8'h55, 1'b0, 1'b1, "t5_clr_drop");
    check("t5_ovf_set_wins", 32'(bus.overflow), 32'd1);
    tick(1'b0, 8'h00, 1'b0, 1'b1, "t5_clr");
    check("t5_ovf_clr", 32'(bus.overflow), 32'd0);

    // 6: reset mid-operation
    apply_reset(1'b0, "t6_pre");
    for (int i = 0; i < 5; i++) put_byte(8'($urandom), "t6_fill");
    check("t6_count5", 32'(bus.count), 32'd5);
    apply_reset(1'b0, "t6_rst");

    // Randomized traffic with alternating consumer pace to exercise full/overflow.
    for (int i = 0; i < 800; i++) begin
      bit rx, rd, clr;
      rx  = ($urandom_range(0, 1) == 1);
      rd  = ((i / 200) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      tick(rx, 8'($urandom), rd, clr, "rand");
      if (i == 500) apply_reset(rx, "rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
